piso_serializer_nlane: RTL and testbench
========================================

// Module: piso_serializer_nlane
// PURPOSE
//  Parametrised multi-lane parallel-in/serial-out serializer for the Transceiver TX path.
//  Accepts DATA_WIDTH-bit words via valid/ready, slices each into DATA_WIDTH/LANES beats of LANES bits.
//  A one-entry holding buffer lets back-to-back words stream with no idle beat between them.
//  Sits between the framing logic and the line driver; successor to the fixed-width serializer_PISO.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits; must be a multiple of LANES
//  LANES       2  bits emitted per beat (1..DATA_WIDTH)
//  MSB_FIRST   1  1: most-significant slice first; 0: least-significant slice first
// PORTS
//  clk        in   1           single clock; all logic on posedge
//  rst        in   1           asynchronous, active-low reset
//  data_in    in   DATA_WIDTH  word to serialize; sampled when load && ready
//  load       in   1           word valid from source
//  ready      out  1           buffer can accept a word
//  srl_out    out  LANES       current serial beat
//  shift      out  1           srl_out carries a valid beat this cycle
//  tx_active  out  1           a word (incl. parity beat if enabled) is being emitted
//  done       out  1           1-cycle pulse coincident with the final beat of a word
// BEHAVIOUR
//  - BEATS = DATA_WIDTH/LANES; beat counter width $clog2(BEATS+1).
//  - Reset (rst=0, async): buffer emptied, FSM->IDLE, srl_out=0, shift=0, tx_active=0, done=0, ready=1.
//  - ready = ~hold_valid (from register, no combinational path from load).
//  - Accept: edge where load && ready -> data_in captured in holding buffer, hold_valid=1. load while ready=0 is ignored.
//  - FSM IDLE: if hold_valid at edge -> shifter loads buffer, buffer empties, -> SHIFT.
//    Latency: load sampled at edge N -> first beat on srl_out after edge N+1 (shift=1, tx_active=1).
//  - SHIFT: one beat per cycle; srl_out = next slice per MSB_FIRST. On last beat (done=1):
//    hold_valid -> shifter reloads at that edge, stays SHIFT (zero gap); else -> IDLE (or PARITY if enabled).
//  - Simultaneous buffer drain and new accept on same edge: new word captured, hold_valid stays 1.
//  - IDLE: srl_out=0, shift=0, tx_active=0. tx_active deasserts the cycle after the final beat.
//  - Mid-operation reset: word in flight and buffered word discarded; no done pulse.
//  - LANES==DATA_WIDTH: BEATS=1, every shifter cycle is a last beat.
// CONFIGURATION
//  - Macro SRLZR_PARITY_EN defined: after the last data beat, one extra PARITY beat:
//    srl_out[0] = even parity (XOR) of the word, upper lanes 0; shift=1; done moves to this beat;
//    buffered word loads at the parity-beat edge. Word takes BEATS+1 cycles.
//  - Undefined: no PARITY state; word takes exactly BEATS cycles.
// STRUCTURE
//  - Package srlzr_pkg: state enum {IDLE, SHIFT, PARITY}, beats_f(DATA_WIDTH,LANES) function, width asserts.
//  - Sub-module srlzr_hold_buf: one-entry buffer (data, hold_valid, ready, pop). FSM/shifter in top.
// TESTING
//  1 DATA_WIDTH=8,LANES=2,MSB_FIRST=1, load 0xB4 -> srl_out 10,11,01,00 on 4 consecutive cycles, shift=1, done on 4th.
//  2 Same with MSB_FIRST=0, load 0xB4 -> srl_out 00,01,11,10.
//  3 Back-to-back 0xB4 then 0x5A -> 8 contiguous beats 10,11,01,00,01,01,10,10; tx_active never drops; 2 done pulses.
//  4 Load 3 words while first shifting -> third held off (ready=0) until buffer drains; no word lost or duplicated.
//  5 rst low on beat 2 of 0xB4 -> all outputs 0, ready=1 same cycle; next word 0x0F serializes cleanly 00,00,11,11.
//  6 SRLZR_PARITY_EN: 0xB5 -> 10,11,01,01 then parity beat 01; 0xB4 -> parity beat 00; done on 5th beat.

Source files
------------

// File: rtl/srlzr_pkg.sv
// ============================================================================
// srlzr_pkg : shared types and helpers for the multi-lane PISO serializer
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package srlzr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int beats_f(input int dw, input int lanes);
    return dw / lanes;
  endfunction

  function automatic bit widths_ok(input int dw, input int lanes);
    return (lanes >= 1) && (lanes <= dw) && ((dw % lanes) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/srlzr_hold_buf.sv
// ============================================================================
// srlzr_hold_buf : one-entry holding buffer in front of the serializer shifter
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module srlzr_hold_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  hold_valid,
  output logic                  ready
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  w_accept;

  // ready comes straight from the flop so there is no load->ready path
  assign ready      = ~r_valid;
  assign w_accept   = load & ready;
  assign word       = r_data;
  assign hold_valid = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= data_in;
        r_valid <= 1'b1;
      end else if (pop) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_serializer_nlane.sv
// ============================================================================
// piso_serializer_nlane : N-lane parallel-in/serial-out serializer, zero-gap
//                         streaming; optional parity beat via SRLZR_PARITY_EN
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer_nlane
  import srlzr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  ready,
  output logic [LANES-1:0]      srl_out,
  output logic                  shift,
  output logic                  tx_active,
  output logic                  done
);

  localparam int BEATS = beats_f(DATA_WIDTH, LANES);
  localparam int CW    = $clog2(BEATS + 1);

  if (!widths_ok(DATA_WIDTH, LANES)) begin : g_bad_cfg
    $error("DATA_WIDTH must be a non-zero multiple of LANES");
  end

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] w_buf_word;
  logic                  w_hold_valid;
  logic                  w_pop;
  logic                  w_load_sh;
  logic                  w_adv;
  logic                  w_last;
  logic [LANES-1:0]      w_slice;
  logic [DATA_WIDTH-1:0] w_shifted;

  srlzr_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .pop        (w_pop),
    .word       (w_buf_word),
    .hold_valid (w_hold_valid),
    .ready      (ready)
  );

  assign w_last    = (r_cnt == CW'(BEATS - 1));
  assign w_slice   = (MSB_FIRST != 0) ? r_shreg[DATA_WIDTH-1 -: LANES] : r_shreg[LANES-1:0];
  assign w_shifted = (MSB_FIRST != 0) ? (r_shreg << LANES) : (r_shreg >> LANES);

`ifdef SRLZR_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_load_sh) begin
      r_par <= ^w_buf_word;
    end
  end
`endif

  always_comb begin
    w_next    = r_state;
    srl_out   = '0;
    shift     = 1'b0;
    tx_active = 1'b0;
    done      = 1'b0;
    w_pop     = 1'b0;
    w_load_sh = 1'b0;
    w_adv     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hold_valid) begin
          w_pop     = 1'b1;
          w_load_sh = 1'b1;
          w_next    = SHIFT;
        end
      end
      SHIFT: begin
        shift     = 1'b1;
        tx_active = 1'b1;
        srl_out   = w_slice;
        if (!w_last) begin
          w_adv = 1'b1;
        end else begin
`ifdef SRLZR_PARITY_EN
          w_next = PARITY;
`else
          // reload on the final beat edge keeps back-to-back words gap-free
          done = 1'b1;
          if (w_hold_valid) begin
            w_pop     = 1'b1;
            w_load_sh = 1'b1;
          end else begin
            w_next = IDLE;
          end
`endif
        end
      end
`ifdef SRLZR_PARITY_EN
      PARITY: begin
        shift      = 1'b1;
        tx_active  = 1'b1;
        srl_out[0] = r_par;
        done       = 1'b1;
        if (w_hold_valid) begin
          w_pop     = 1'b1;
          w_load_sh = 1'b1;
          w_next    = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_sh) begin
        r_shreg <= w_buf_word;
        r_cnt   <= '0;
      end else if (w_adv) begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer_nlane.sv
// ============================================================================
// tb_piso_serializer_nlane : directed table + randomized timeline-model bench
// Revision                 : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer_nlane;

  localparam int DW    = 8;
  localparam int LN    = 2;
  localparam int BEATS = DW / LN;
`ifdef SRLZR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WL    = BEATS + PAR;
  localparam int TMAX  = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          load;
  logic          ready_m, shift_m, tx_m, done_m;
  logic          ready_l, shift_l, tx_l, done_l;
  logic [LN-1:0] srl_m, srl_l;

  always #5 clk = ~clk;

  piso_serializer_nlane #(.DATA_WIDTH(DW), .LANES(LN), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready_m),
    .srl_out(srl_m), .shift(shift_m), .tx_active(tx_m), .done(done_m));

  piso_serializer_nlane #(.DATA_WIDTH(DW), .LANES(LN), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready_l),
    .srl_out(srl_l), .shift(shift_l), .tx_active(tx_l), .done(done_l));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // A word accepted at edge E starts at max(E+1, shifter free edge) and
  // occupies WL consecutive edges; the buffer stays full until it starts.
  bit       exp_v [TMAX];
  bit       exp_d [TMAX];
  logic [1:0] exp_m [TMAX];
  logic [1:0] exp_l [TMAX];
  int       ec, free_at, pend_start;
  logic [1:0] obs_m [$];

  function automatic logic [1:0] slice_of(input logic [DW-1:0] w, input int k, input bit msb);
    logic [DW-1:0] t;
    if (k >= BEATS) return {1'b0, ^w};
    t = msb ? (w >> (DW - LN * (k + 1))) : (w >> (LN * k));
    return t[1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TMAX; i++) begin
      exp_v[i] = 1'b0; exp_d[i] = 1'b0; exp_m[i] = '0; exp_l[i] = '0;
    end
    ec = 0; free_at = 0; pend_start = -1;
    obs_m.delete();
  endtask

  task automatic schedule(input int e, input logic [DW-1:0] w);
    int s;
    s = (e + 1 > free_at) ? e + 1 : free_at;
    for (int k = 0; k < WL; k++) begin
      if (s + k < TMAX) begin
        exp_v[s+k] = 1'b1;
        exp_d[s+k] = (k == WL - 1);
        exp_m[s+k] = slice_of(w, k, 1'b1);
        exp_l[s+k] = slice_of(w, k, 1'b0);
      end
    end
    free_at    = s + WL;
    pend_start = s;
  endtask

  task automatic compare_now();
    bit v;
    v = (ec < TMAX) ? exp_v[ec] : 1'b0;
    chk("srl_msb",   srl_m,   v ? exp_m[ec] : 2'b00);
    chk("srl_lsb",   srl_l,   v ? exp_l[ec] : 2'b00);
    chk("shift_msb", shift_m, v);
    chk("shift_lsb", shift_l, v);
    chk("tx_msb",    tx_m,    v);
    chk("done_msb",  done_m,  v & exp_d[ec]);
    chk("done_lsb",  done_l,  v & exp_d[ec]);
    chk("ready_msb", ready_m, pend_start <= ec);
    chk("ready_lsb", ready_l, pend_start <= ec);
    if (shift_m) obs_m.push_back(srl_m);
  endtask

  // source holds load high with the same word until it is accepted
  task automatic run_stream(input logic [DW-1:0] words [$], input int p_load);
    int idx;
    bit acc;
    idx = 0;
    acc = 1'b0;
    model_clear();
    forever begin
      @(negedge clk);
      compare_now();
      if (idx == words.size() && ec >= free_at) break;
      if (ec > TMAX - 16) begin
        chk("stream_timeout", ec, free_at);
        break;
      end
      if (acc) load = 1'b0;
      if (idx < words.size()) begin
        if (!load && ($urandom_range(0, 99) < p_load)) begin
          load    = 1'b1;
          data_in = words[idx];
        end
      end
      if (!load) data_in = DW'($urandom);
      acc = load && (pend_start < ec + 1);
      @(posedge clk);
      ec++;
      if (acc) begin
        schedule(ec, data_in);
        idx++;
      end
    end
    load = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] w;
    logic [7:0] em;   // MSB-first beats, first beat in the top bits
    logic [7:0] el;   // LSB-first beats, first beat in the top bits
    logic       par;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [DW-1:0] q [$];
    logic [31:0]   pk_act, pk_exp;
    logic [1:0]    want [$];
    vec_t          r;
    logic [1:0]    em_b, el_b;

    tbl[0] = '{8'h0F, 8'b00_00_11_11, 8'b11_11_00_00, 1'b0};
    tbl[1] = '{8'hB4, 8'b10_11_01_00, 8'b00_01_11_10, 1'b0};
    tbl[2] = '{8'h5A, 8'b01_01_10_10, 8'b10_10_01_01, 1'b0};
    tbl[3] = '{8'hB5, 8'b10_11_01_01, 8'b01_01_11_10, 1'b1};
    tbl[4] = '{8'hFF, 8'b11_11_11_11, 8'b11_11_11_11, 1'b0};
    tbl[5] = '{8'h01, 8'b00_00_00_01, 8'b01_00_00_00, 1'b1};

    rst = 1'b0; load = 1'b0; data_in = '0;
    #3;
    chk("rst_ready",  ready_m, 1'b1);
    chk("rst_srl",    srl_m,   2'b00);
    chk("rst_shift",  shift_m, 1'b0);
    chk("rst_tx",     tx_m,    1'b0);
    chk("rst_done",   done_m,  1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // mid-word reset: second beat of 0xB4 on screen, then pull reset
    @(negedge clk); data_in = 8'hB4; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); chk("mr_beat1", srl_m, 2'b10);
    @(negedge clk); chk("mr_beat2", srl_m, 2'b11);
    rst = 1'b0;
    #1;
    chk("mr_srl_msb", srl_m,   2'b00);
    chk("mr_srl_lsb", srl_l,   2'b00);
    chk("mr_shift",   shift_m, 1'b0);
    chk("mr_tx",      tx_m,    1'b0);
    chk("mr_done",    done_m,  1'b0);
    chk("mr_ready",   ready_m, 1'b1);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      r = tbl[i];
      @(negedge clk); data_in = r.w; load = 1'b1;
      @(posedge clk);
      @(negedge clk); load = 1'b0;
      chk("tb_held_ready", ready_m, 1'b0);
      chk("tb_idle_shift", shift_m, 1'b0);
      for (int k = 0; k < WL; k++) begin
        @(negedge clk);
        em_b = (k < BEATS) ? r.em[7-2*k -: 2] : {1'b0, r.par};
        el_b = (k < BEATS) ? r.el[7-2*k -: 2] : {1'b0, r.par};
        chk("tb_srl_msb", srl_m,   em_b);
        chk("tb_srl_lsb", srl_l,   el_b);
        chk("tb_shift",   shift_l, 1'b1);
        chk("tb_tx",      tx_l,    1'b1);
        chk("tb_done",    done_m,  k == WL - 1);
      end
      @(negedge clk);
      chk("tb_end_tx",    tx_m,    1'b0);
      chk("tb_end_shift", shift_m, 1'b0);
      chk("tb_end_ready", ready_m, 1'b1);
    end

    // back-to-back pair: beat stream must be contiguous
    q = '{8'hB4, 8'h5A};
    run_stream(q, 100);
    want = '{2'b10, 2'b11, 2'b01, 2'b00};
    if (PAR != 0) want.push_back(2'b00);
    want.push_back(2'b01); want.push_back(2'b01);
    want.push_back(2'b10); want.push_back(2'b10);
    if (PAR != 0) want.push_back(2'b00);
    pk_act = '0; pk_exp = '0;
    foreach (obs_m[i]) pk_act = (pk_act << 2) | 32'(obs_m[i]);
    foreach (want[i])  pk_exp = (pk_exp << 2) | 32'(want[i]);
    chk("b2b_stream", pk_act, pk_exp);
    chk("b2b_count",  obs_m.size(), want.size());

    // three words offered while the first is shifting
    q = '{8'h3C, 8'hC3, 8'h81};
    run_stream(q, 100);

    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(DW'($urandom));
    run_stream(q, 55);
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back(DW'($urandom));
    run_stream(q, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
